// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches under a credit limit and buffers
// in-order responses for decode. Optional macro: FETCH_MISALIGN_CHECK_EN.
module fetch_queue #(
    parameter int unsigned        BITSIZE  = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [BITSIZE-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [BITSIZE-1:0]           imem_req_addr,
    input  logic                         imem_resp_valid,
    input  logic [31:0]                  imem_resp_data,
    input  logic                         redirect,
    input  logic [BITSIZE-1:0]           redirect_pc,
    output logic                         ins_valid,
    input  logic                         ins_ready,
    output logic [31:0]                  ins_data,
    output logic [BITSIZE-1:0]           ins_pc,
    output logic [$clog2(DEPTH):0]       occupancy,
    output logic                         misalign
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [BITSIZE-1:0] pc;
        logic [31:0]        ins;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [BITSIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [BITSIZE-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]      outstanding_q, outstanding_d;
    logic [CW-1:0]      discard_q, discard_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic               misalign_q, misalign_d;

    logic [BITSIZE-1:0] redir_pc;
    logic               redir_mis;
    logic [CW:0]        credit_used;
    logic               accept, resp_take, push, pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_pc  = redirect_pc;
    assign redir_mis = |redirect_pc[1:0];
`else
    assign redir_pc  = redirect_pc & ~BITSIZE'(3);
    assign redir_mis = 1'b0;
`endif

    // Buffered entries plus in-flight requests (including ones to be discarded)
    // never exceed DEPTH, so a response always finds a free slot.
    assign credit_used    = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req_valid = !redirect && !misalign_q && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;

    assign ins_valid = (count_q != '0);
    assign ins_data  = mem_q[head_q].ins;
    assign ins_pc    = mem_q[head_q].pc;
    assign occupancy = count_q;
    assign misalign  = misalign_q;

    assign accept    = imem_req_valid && imem_req_ready;
    assign resp_take = imem_resp_valid && (outstanding_q != '0);
    assign push      = resp_take && (discard_q == '0) && !redirect;
    assign pop       = ins_valid && ins_ready && !redirect;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        misalign_d    = misalign_q;

        if (redirect) begin
            // Everything still in flight, minus a response landing this cycle, is stale.
            fetch_pc_d    = redir_pc;
            resp_pc_d     = redir_pc;
            outstanding_d = outstanding_q - CW'(resp_take);
            discard_d     = outstanding_q - CW'(resp_take);
            count_d       = '0;
            head_d        = '0;
            tail_d        = '0;
            misalign_d    = redir_mis;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + BITSIZE'(4);
            end
            outstanding_d = outstanding_q + CW'(accept) - CW'(resp_take);
            if (resp_take && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                tail_d    = tail_q + PW'(1);
                resp_pc_d = resp_pc_q + BITSIZE'(4);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            misalign_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            misalign_q    <= misalign_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[tail_q] <= '{pc: resp_pc_q, ins: imem_resp_data};
        end
    end
endmodule
